ins_encoder: RTL

Pipelined RV32I instruction encoder, the inverse of the core's instruction decoder. It accepts decoded instruction fields (class, funct3, register addresses, immediate, CSR address) over a valid/ready handshake. It range-checks them and packs them into a 32-bit instruction word. Words leave through a 2-entry output buffer with valid/ready. Its consumers are the debug instruction-injection path and the self-test stimulus generator, both of which feed words into the fetch side ahead of the decoder.

---
 rtl/ins_encoder_if.sv | 42 ++++
 rtl/ins_encoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ins_encoder_if.sv
// ins_encoder_if -- request/response bundle for the RV32I instruction encoder.
//
// Request side (master -> slave):
//   req_valid_i / req_ready_o   handshake, transfer when both are high
//   req_class_i                 instruction class (0..12 legal, 13..15 illegal)
//   req_funct3_i, req_alt_i     funct3 and the funct7/EBREAK selector
//   req_regd_i/regs1_i/regs2_i  register addresses
//   req_imm_i                   immediate (P_XLEN bits), zimm for CSR-immediate
//   req_csr_addr_i              CSR address
// Word side (slave -> master):
//   ins_valid_o / ins_ready_i   handshake on the buffered head word
//   ins_o, ins_err_o            encoded word and its encode-error flag
interface ins_encoder_if #(
  parameter int P_XLEN = 32
) ();
  logic              req_valid_i;
  logic              req_ready_o;
  logic [3:0]        req_class_i;
  logic [2:0]        req_funct3_i;
  logic              req_alt_i;
  logic [4:0]        req_regd_i;
  logic [4:0]        req_regs1_i;
  logic [4:0]        req_regs2_i;
  logic [P_XLEN-1:0] req_imm_i;
  logic [11:0]       req_csr_addr_i;
  logic              ins_valid_o;
  logic              ins_ready_i;
  logic [31:0]       ins_o;
  logic              ins_err_o;

  modport master (
    output req_valid_i, req_class_i, req_funct3_i, req_alt_i, req_regd_i,
           req_regs1_i, req_regs2_i, req_imm_i, req_csr_addr_i, ins_ready_i,
    input  req_ready_o, ins_valid_o, ins_o, ins_err_o
  );

  modport slave (
    input  req_valid_i, req_class_i, req_funct3_i, req_alt_i, req_regd_i,
           req_regs1_i, req_regs2_i, req_imm_i, req_csr_addr_i, ins_ready_i,
    output req_ready_o, ins_valid_o, ins_o, ins_err_o
  );
endinterface

// File: rtl/ins_encoder.sv
// ins_encoder -- packs decoded RV32I fields into a 32-bit instruction word.
//
// Ports:
//   clk_i    clock, all logic on the rising edge
//   reset_i  synchronous active-high reset; empties the buffer, clears ins_o
//   flush_i  drops every buffered word; blocks acceptance while high
//   bus      ins_encoder_if.slave: request handshake in, word handshake out
//
// The encoder is purely combinational on the request; the result is written
// into a 2-entry FIFO when the request is accepted. Out-of-range fields give
// ins_err_o=1 with an all-zero word. req_ready_o comes from registered state
// only, so the consumer's ready never reaches the producer combinationally.
module ins_encoder #(
  parameter int P_XLEN = 32
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         flush_i,
  ins_encoder_if.slave bus
);
  localparam logic [3:0] CLS_LUI = 4'd0, CLS_AUIPC = 4'd1, CLS_JAL = 4'd2,
                         CLS_JALR = 4'd3, CLS_BRANCH = 4'd4, CLS_LOAD = 4'd5,
                         CLS_STORE = 4'd6, CLS_OPIMM = 4'd7, CLS_OP = 4'd8,
                         CLS_FENCE = 4'd9, CLS_CSR = 4'd10, CLS_CSRI = 4'd11,
                         CLS_SYS = 4'd12;

  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111,
                         OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111,
                         OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
                         OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011,
                         OPC_OP = 7'b0110011, OPC_FENCE = 7'b0001111,
                         OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

  logic [P_XLEN-1:0] imm;
  logic [2:0]        f3;
  logic              alt;
  logic [4:0]        rd, rs1, rs2;

  assign imm = bus.req_imm_i;
  assign f3  = bus.req_funct3_i;
  assign alt = bus.req_alt_i;
  assign rd  = bus.req_regd_i;
  assign rs1 = bus.req_regs1_i;
  assign rs2 = bus.req_regs2_i;

  // A value fits an N-bit signed field when every bit from N-1 upward is a
  // copy of the sign bit.
  logic fits_i, fits_b, fits_j, fits_5;
  assign fits_i = (&imm[P_XLEN-1:11]) | ~(|imm[P_XLEN-1:11]);
  assign fits_b = (&imm[P_XLEN-1:12]) | ~(|imm[P_XLEN-1:12]);
  assign fits_j = (&imm[P_XLEN-1:20]) | ~(|imm[P_XLEN-1:20]);
  assign fits_5 = ~(|imm[P_XLEN-1:5]);

  logic [31:0] enc_word;
  logic        enc_err;

  always_comb begin
    enc_word = 32'h0;
    enc_err  = 1'b0;
    case (bus.req_class_i)
      CLS_LUI, CLS_AUIPC: begin
        enc_err  = |imm[11:0];
        enc_word = {imm[31:12], rd,
                    (bus.req_class_i == CLS_LUI) ? OPC_LUI : OPC_AUIPC};
      end
      CLS_JAL: begin
        enc_err  = ~fits_j | imm[0];
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      end
      CLS_JALR: begin
        enc_err  = (f3 != 3'd0) | ~fits_i;
        enc_word = {imm[11:0], rs1, f3, rd, OPC_JALR};
      end
      CLS_BRANCH: begin
        enc_err  = (f3 == 3'd2) | (f3 == 3'd3) | ~fits_b | imm[0];
        enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11],
                    OPC_BRANCH};
      end
      CLS_LOAD: begin
        enc_err  = (f3 == 3'd3) | (f3 == 3'd6) | (f3 == 3'd7) | ~fits_i;
        enc_word = {imm[11:0], rs1, f3, rd, OPC_LOAD};
      end
      CLS_STORE: begin
        enc_err  = (f3 > 3'd2) | ~fits_i;
        enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
      end
      CLS_OPIMM: begin
        if ((f3 == 3'd1) || (f3 == 3'd5)) begin
          // Shifts: shamt in imm[4:0], funct7 chosen by alt (SRAI only).
          enc_err  = ~fits_5 | (alt & (f3 != 3'd5));
          enc_word = {1'b0, alt, 5'b0, imm[4:0], rs1, f3, rd, OPC_OPIMM};
        end else begin
          enc_err  = alt | ~fits_i;
          enc_word = {imm[11:0], rs1, f3, rd, OPC_OPIMM};
        end
      end
      CLS_OP: begin
        enc_err  = alt & (f3 != 3'd0) & (f3 != 3'd5);
        enc_word = {1'b0, alt, 5'b0, rs2, rs1, f3, rd, OPC_OP};
      end
      CLS_FENCE: begin
        enc_word = {imm[11:0], rs1, f3, rd, OPC_FENCE};
      end
      CLS_CSR: begin
        enc_err  = (f3 == 3'd0) | f3[2];
        enc_word = {bus.req_csr_addr_i, rs1, f3, rd, OPC_SYSTEM};
      end
      CLS_CSRI: begin
        enc_err  = ~f3[2] | (f3 == 3'd4) | ~fits_5;
        enc_word = {bus.req_csr_addr_i, imm[4:0], f3, rd, OPC_SYSTEM};
      end
      CLS_SYS: begin
        // ECALL = 0x00000073, EBREAK sets bit 20.
        enc_word = {11'b0, alt, 20'h00073};
      end
      default: enc_err = 1'b1;
    endcase
    if (enc_err) enc_word = 32'h0;
  end

  // Output FIFO: head entry drives the outputs, tail holds the second word.
  buf_state_t  state_reg, state_next;
  logic [32:0] head_reg, head_next, tail_reg, tail_next;
  logic        req_ready, push, pop;

  assign req_ready = ~reset_i & ~flush_i & (state_reg != BUF_FULL);
  assign push      = bus.req_valid_i & req_ready;
  assign pop       = (state_reg != BUF_EMPTY) & bus.ins_ready_i;

  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    if (flush_i) begin
      state_next = BUF_EMPTY;
    end else begin
      case (state_reg)
        BUF_EMPTY: begin
          if (push) begin
            head_next  = {enc_err, enc_word};
            state_next = BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (push && pop) begin
            head_next = {enc_err, enc_word};
          end else if (push) begin
            tail_next  = {enc_err, enc_word};
            state_next = BUF_FULL;
          end else if (pop) begin
            state_next = BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          // No push is possible here: ready is low while full.
          if (pop) begin
            head_next  = tail_reg;
            state_next = BUF_ONE;
          end
        end
        default: state_next = BUF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg <= BUF_EMPTY;
      head_reg  <= 33'h0;
      tail_reg  <= 33'h0;
    end else begin
      state_reg <= state_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
    end
  end

  assign bus.req_ready_o = req_ready;
  assign bus.ins_valid_o = (state_reg != BUF_EMPTY);
  assign bus.ins_o       = head_reg[31:0];
  assign bus.ins_err_o   = head_reg[32];
endmodule
